// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the program-counter generator.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pc_state_e;

   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_BR   = 3'd1,
      SEL_RAS  = 3'd2,
      SEL_JMP  = 3'd3,
      SEL_TRAP = 3'd4
   } pc_sel_e;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

   // Only these sources carry a target that can be misaligned.
   function automatic logic sel_checks_align(input pc_sel_e s);
      return (s == SEL_JMP) || (s == SEL_RAS) || (s == SEL_BR);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
module pc_ras
   import pc_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] top_o,
   output logic            empty_o,
   output logic            full_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   top_idx, nxt_idx, wr_idx;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we;
   logic            do_pop;

   assign top_idx = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
   assign nxt_idx = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign top_o   = mem_q[top_idx];
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      wr_idx = ptr_q;
      we     = 1'b0;
      if (push_i && do_pop) begin
         // Return and call together: the old top is consumed and replaced.
         wr_idx = top_idx;
         we     = 1'b1;
      end else if (push_i) begin
         we    = 1'b1;
         ptr_d = nxt_idx;
         if (!full_o) cnt_d = cnt_q + 1'b1;
      end else if (do_pop) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         if (we) mem_q[wr_idx] <= data_i;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: prioritised next-PC select, stall/halt, fetch handshake.
// Define PC_GEN_RAS_EN to add the return-address stack.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
   parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC),
   parameter int              INSTR_BYTES = 4,
   parameter int              RAS_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jmp_sel,
   input  logic [XLEN-1:0] alu_target,
   input  logic            trap,
   input  logic            halt,
   input  logic            resume,
   input  logic            ras_push,
   input  logic            ras_pop,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   input  logic            pc_ready,
   output logic            misalign
);

   localparam logic [XLEN-1:0] AMASK = XLEN'(INSTR_BYTES - 1);
   localparam logic [XLEN-1:0] INC   = XLEN'(INSTR_BYTES);

   pc_state_e       state_q, state_d;
   pc_sel_e         sel;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] seq_pc, tgt;
   logic            fire, bad_tgt;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty, ras_full, ras_hit;
   logic            unused_ras;

   assign fire    = pc_valid & pc_ready;
   assign seq_pc  = pc_q + INC;
   assign ras_hit = ras_pop & ~ras_empty;

`ifdef PC_GEN_RAS_EN
   pc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fire & ras_push),
      .pop_i   (fire & (sel == SEL_RAS)),
      .data_i  (seq_pc),
      .top_o   (ras_top),
      .empty_o (ras_empty),
      .full_o  (ras_full)
   );
   assign unused_ras = ras_full;
`else
   assign ras_top    = '0;
   assign ras_empty  = 1'b1;
   assign ras_full   = 1'b0;
   assign unused_ras = ras_full ^ ras_push;
`endif

   always_comb begin
      if (trap)          sel = SEL_TRAP;
      else if (jmp_sel)  sel = SEL_JMP;
      else if (ras_hit)  sel = SEL_RAS;
      else if (br_taken) sel = SEL_BR;
      else               sel = SEL_SEQ;
   end

   always_comb begin
      tgt = seq_pc;
      unique case (sel)
         SEL_TRAP: tgt = TRAP_VEC;
         SEL_JMP:  tgt = alu_target;
         SEL_RAS:  tgt = ras_top;
         SEL_BR:   tgt = br_target;
         default:  tgt = seq_pc;
      endcase
   end

   assign bad_tgt = sel_checks_align(sel) && ((tgt & AMASK) != '0);

   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (fire) begin
         pc_d       = bad_tgt ? TRAP_VEC : tgt;
         misalign_d = bad_tgt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HOLD: state_d = ST_RUN;
         ST_RUN:  if (halt) state_d = ST_HALT;
         ST_HALT: if (resume && !halt) state_d = ST_RUN;
         default: state_d = ST_HOLD;
      endcase
   end

   always_comb begin
      pc_valid = (state_q == ST_RUN);
      pc       = pc_q;
      misalign = misalign_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VEC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
module tb_pc_gen;

   logic        clk;
   logic        rst_n;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp_sel;
   logic [31:0] alu_target;
   logic        trap;
   logic        halt;
   logic        resume;
   logic        ras_push;
   logic        ras_pop;
   logic [31:0] pc;
   logic        pc_valid;
   logic        pc_ready;
   logic        misalign;

   int n_chk;
   int n_err;

   pc_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp_sel    (jmp_sel),
      .alu_target (alu_target),
      .trap       (trap),
      .halt       (halt),
      .resume     (resume),
      .ras_push   (ras_push),
      .ras_pop    (ras_pop),
      .pc         (pc),
      .pc_valid   (pc_valid),
      .pc_ready   (pc_ready),
      .misalign   (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clr();
      br_taken   = 1'b0;
      br_target  = '0;
      jmp_sel    = 1'b0;
      alu_target = '0;
      trap       = 1'b0;
      halt       = 1'b0;
      resume     = 1'b0;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;
   endtask

   task automatic jump(input logic [31:0] t);
      jmp_sel    = 1'b1;
      alu_target = t;
      step();
      clr();
   endtask

   initial begin
      n_chk    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      pc_ready = 1'b1;
      clr();
      step();
      step();
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'b0, pc_valid}, 32'h0);
      check("rst_mis", {31'b0, misalign}, 32'h0);

      // HOLD cycle then sequential fetch
      rst_n = 1'b1;
      #1;
      check("hold_valid", {31'b0, pc_valid}, 32'h0);
      check("hold_pc", pc, 32'h0);
      step();
      for (int i = 0; i < 4; i++) begin
         check("seq_pc", pc, 32'(4 * i));
         check("seq_valid", {31'b0, pc_valid}, 32'h1);
         step();
      end
      check("seq_pc10", pc, 32'h10);

      // stall, with a jump offered that must be ignored
      pc_ready   = 1'b0;
      jmp_sel    = 1'b1;
      alu_target = 32'h300;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc", pc, 32'h10);
      end
      clr();
      pc_ready = 1'b1;
      step();
      check("unstall_pc", pc, 32'h14);

      // priority
      br_taken   = 1'b1;
      br_target  = 32'h40;
      jmp_sel    = 1'b1;
      alu_target = 32'h80;
      step();
      check("jmp_over_br", pc, 32'h80);
      trap = 1'b1;
      step();
      check("trap_prio", pc, 32'h100);
      check("trap_nomis", {31'b0, misalign}, 32'h0);
      clr();
      br_taken  = 1'b1;
      br_target = 32'h200;
      step();
      clr();
      check("br_pc", pc, 32'h200);

      // misaligned targets
      jump(32'h82);
      check("mis_jmp_pc", pc, 32'h100);
      check("mis_jmp_flag", {31'b0, misalign}, 32'h1);
      step();
      check("mis_pulse_end", {31'b0, misalign}, 32'h0);
      check("after_mis_pc", pc, 32'h104);
      br_taken  = 1'b1;
      br_target = 32'h41;
      step();
      clr();
      check("mis_br_pc", pc, 32'h100);
      check("mis_br_flag", {31'b0, misalign}, 32'h1);

      // wrap-around
      jump(32'hFFFF_FFFC);
      check("top_pc", pc, 32'hFFFF_FFFC);
      step();
      check("wrap_pc", pc, 32'h0);

      // halt / resume
      jump(32'h20);
      check("pre_halt_pc", pc, 32'h20);
      halt = 1'b1;
      step();
      halt = 1'b0;
      check("halt_valid", {31'b0, pc_valid}, 32'h0);
      check("halt_pc", pc, 32'h24);
      trap = 1'b1;
      step();
      trap = 1'b0;
      check("halt_trap_ign", pc, 32'h24);
      halt   = 1'b1;
      resume = 1'b1;
      step();
      check("halt_and_resume", {31'b0, pc_valid}, 32'h0);
      halt = 1'b0;
      step();
      resume = 1'b0;
      check("resume_valid", {31'b0, pc_valid}, 32'h1);
      check("resume_pc", pc, 32'h24);
      step();
      check("resume_seq", pc, 32'h28);

`ifdef PC_GEN_RAS_EN
      jump(32'h10);
      ras_push = 1'b1;
      step();
      clr();
      check("ras_push1", pc, 32'h14);
      jump(32'h30);
      ras_push = 1'b1;
      step();
      clr();
      step();
      check("ras_pre_pop", pc, 32'h38);
      ras_pop = 1'b1;
      step();
      check("ras_pop1", pc, 32'h34);
      step();
      check("ras_pop2", pc, 32'h14);
      step();
      check("ras_pop_empty", pc, 32'h18);
      ras_pop  = 1'b0;
      ras_push = 1'b1;
      for (int i = 0; i < 5; i++) step();
      ras_push = 1'b0;
      check("ras_push5", pc, 32'h2C);
      ras_pop = 1'b1;
      step();
      check("ras_ov1", pc, 32'h2C);
      step();
      check("ras_ov2", pc, 32'h28);
      step();
      check("ras_ov3", pc, 32'h24);
      step();
      check("ras_ov4", pc, 32'h20);
      step();
      check("ras_ov_empty", pc, 32'h24);
      clr();
      // push and pop together: redirect to old top, replace it
      ras_push = 1'b1;
      step();
      clr();
      jump(32'h60);
      ras_push = 1'b1;
      ras_pop  = 1'b1;
      step();
      clr();
      check("ras_pp_pc", pc, 32'h28);
      ras_pop = 1'b1;
      step();
      clr();
      check("ras_pp_top", pc, 32'h64);
`else
      ras_push = 1'b1;
      step();
      clr();
      check("noras_push", pc, 32'h2C);
      ras_pop = 1'b1;
      step();
      clr();
      check("noras_pop", pc, 32'h30);
`endif

      // asynchronous reset mid-operation
      jump(32'h500);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_pc", pc, 32'h0);
      check("arst_valid", {31'b0, pc_valid}, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      check("arst_run", {31'b0, pc_valid}, 32'h1);
      check("arst_run_pc", pc, 32'h0);
`ifdef PC_GEN_RAS_EN
      ras_pop = 1'b1;
      step();
      clr();
      check("arst_ras_clr", pc, 32'h4);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
